multu_hilo: RTL and testbench

Multi-cycle unsigned 32×32 multiplier with architectural HI/LO registers, executing the MULTU function code (6'b011001) and the MFHI/MFLO read-back codes. It sits beside the single-cycle ALU, takes the same funct field and operands, and returns 32-bit results to the ALU result path. It uses a start/busy/done handshake so the controller can stall while a multiply is in flight.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/multu_hilo_if.sv | 24 ++
 rtl/multu_hilo_step.sv | 19 +
 rtl/multu_hilo.sv | 105 ++++++++++
 tb/tb_multu_hilo.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU/multiplier definitions: funct codes, multiplier FSM states, operand width.
// Used by the single-cycle ALU result mux and the HI/LO multiplier.
package alu_pkg;

   localparam int ALU_WIDTH = 32;

   localparam logic [5:0] FUNCT_AND   = 6'b100100;
   localparam logic [5:0] FUNCT_OR    = 6'b100101;
   localparam logic [5:0] FUNCT_ADD   = 6'b100000;
   localparam logic [5:0] FUNCT_SUB   = 6'b100010;
   localparam logic [5:0] FUNCT_SLT   = 6'b101010;
   localparam logic [5:0] FUNCT_SLL   = 6'b000000;
   localparam logic [5:0] FUNCT_MULTU = 6'b011001;
   localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
   localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } mdu_state_e;

   function automatic logic is_mdu_funct(input logic [5:0] funct);
      return (funct == FUNCT_MULTU) || (funct == FUNCT_MFHI) || (funct == FUNCT_MFLO);
   endfunction

endpackage

// File: rtl/multu_hilo_if.sv
// Request/response bundle between the controller and the HI/LO multiplier.
interface multu_hilo_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [5:0]       funct;
   logic [WIDTH-1:0] dataA;
   logic [WIDTH-1:0] dataB;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] dataOut;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, funct, dataA, dataB,
      input  busy, done, dataOut, hi, lo
   );

   modport slave (
      input  start, funct, dataA, dataB,
      output busy, done, dataOut, hi, lo
   );
endinterface

// File: rtl/multu_hilo_step.sv
// One shift-add iteration of the unsigned multiplier: conditionally add A into the
// upper half, then shift the whole product right by one keeping the add carry.
module multu_step #(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] p,
   input  logic [WIDTH-1:0]   a,
   output logic [2*WIDTH-1:0] p_next
);
   logic [WIDTH:0] upper_sum;

   always_comb begin
      upper_sum = {1'b0, p[2*WIDTH-1:WIDTH]};
      if (p[0]) begin
         upper_sum = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, a};
      end
      p_next = {upper_sum, p[WIDTH-1:1]};
   end
endmodule

// File: rtl/multu_hilo.sv
// Multi-cycle MULTU with architectural HI/LO and MFHI/MFLO read-back.
// MULTU: W+1 cycles start-to-done; MFHI/MFLO: 1 cycle. Starts while busy are dropped.
module multu_hilo
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input logic           clk,
   input logic           rst,
   multu_hilo_if.slave   bus
);
   localparam int CW = $clog2(WIDTH);

   mdu_state_e         state_q, state_d;
   logic [CW-1:0]      count_q, count_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [2*WIDTH-1:0] p_q, p_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic [WIDTH-1:0]   data_out_q, data_out_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [2*WIDTH-1:0] p_next;

   multu_step #(.WIDTH(WIDTH)) u_step (
      .p      (p_q),
      .a      (a_q),
      .p_next (p_next)
   );

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      a_d        = a_q;
      p_d        = p_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      data_out_d = data_out_q;
      busy_d     = 1'b0;
      done_d     = 1'b0;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            // DONE falls back to IDLE unless a new request is taken on the same edge
            state_d = ST_IDLE;
            if (bus.start && is_mdu_funct(bus.funct)) begin
               if (bus.funct == FUNCT_MULTU) begin
                  a_d     = bus.dataA;
                  p_d     = {{WIDTH{1'b0}}, bus.dataB};
                  count_d = '0;
                  busy_d  = 1'b1;
                  state_d = ST_RUN;
               end else begin
                  data_out_d = (bus.funct == FUNCT_MFHI) ? hi_q : lo_q;
                  done_d     = 1'b1;
                  state_d    = ST_DONE;
               end
            end
         end
         ST_RUN: begin
            p_d     = p_next;
            count_d = count_q + CW'(1);
            busy_d  = 1'b1;
            if (count_q == CW'(WIDTH - 1)) begin
               hi_d    = p_next[2*WIDTH-1:WIDTH];
               lo_d    = p_next[WIDTH-1:0];
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         a_q        <= '0;
         p_q        <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         data_out_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         a_q        <= a_d;
         p_q        <= p_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         data_out_q <= data_out_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.dataOut = data_out_q;
   assign bus.hi      = hi_q;
   assign bus.lo      = lo_q;
endmodule

// File: tb/tb_multu_hilo.sv
// Directed-vector bench for multu_hilo: MULTU products, MFHI/MFLO read-back, ignored starts, reset abort.
module tb_multu_hilo;
   import alu_pkg::*;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_pass;
   logic [31:0] m_hi, m_lo;

   multu_hilo_if #(.WIDTH(32)) bus ();

   multu_hilo #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request for exactly one edge, then scramble operands to prove they were latched.
   task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      bus.start = 1'b1;
      bus.funct = f;
      bus.dataA = a;
      bus.dataB = b;
      tick();
      bus.start = 1'b0;
      bus.dataA = 32'hDEAD_BEEF;
      bus.dataB = 32'hCAFE_F00D;
   endtask

   // Runs a MULTU to completion; leaves the bench sampled just after the done edge.
   task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int cycles;
      int busy_cnt;
      issue(FUNCT_MULTU, a, b);
      chk_eq({tag, "_busy_n"}, 32'(bus.busy), 32'd1);
      busy_cnt = 1;
      cycles   = 0;
      while (!bus.done && cycles < 100) begin
         tick();
         cycles++;
         if (bus.busy) busy_cnt++;
         if (cycles == 16) begin
            chk_eq({tag, "_hi_mid"}, bus.hi, m_hi);
            chk_eq({tag, "_lo_mid"}, bus.lo, m_lo);
         end
      end
      chk_eq({tag, "_latency"}, 32'(cycles), 32'd32);
      chk_eq({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd32);
      chk_eq({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
      chk_eq({tag, "_hi"}, bus.hi, exp_hi);
      chk_eq({tag, "_lo"}, bus.lo, exp_lo);
      m_hi = exp_hi;
      m_lo = exp_lo;
   endtask

   initial begin
      int pulses;
      n_chk     = 0;
      n_pass    = 0;
      m_hi      = '0;
      m_lo      = '0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.funct = FUNCT_ADD;
      bus.dataA = '0;
      bus.dataB = '0;
      tick();
      tick();
      rst = 1'b0;
      chk_eq("rst_busy", 32'(bus.busy), 32'd0);
      chk_eq("rst_done", 32'(bus.done), 32'd0);
      chk_eq("rst_dout", bus.dataOut, 32'd0);
      chk_eq("rst_hi", bus.hi, 32'd0);
      chk_eq("rst_lo", bus.lo, 32'd0);

      run_mult("m3x5", 32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F);
      tick();
      chk_eq("m3x5_done_clr", 32'(bus.done), 32'd0);

      run_mult("mff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      tick();

      run_mult("mzero", 32'h1234_5678, 32'd0, 32'd0, 32'd0);
      tick();
      issue(FUNCT_MFLO, 32'd0, 32'd0);
      chk_eq("mflo0_done", 32'(bus.done), 32'd1);
      chk_eq("mflo0_busy", 32'(bus.busy), 32'd0);
      chk_eq("mflo0_dout", bus.dataOut, 32'd0);
      tick();

      // MULTU then MFHI, MFLO each accepted straight out of DONE
      run_mult("m64k", 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);
      bus.start = 1'b1;
      bus.funct = FUNCT_MFHI;
      tick();
      chk_eq("b2b_mfhi_done", 32'(bus.done), 32'd1);
      chk_eq("b2b_mfhi_dout", bus.dataOut, 32'd1);
      bus.funct = FUNCT_MFLO;
      tick();
      bus.start = 1'b0;
      chk_eq("b2b_mflo_done", 32'(bus.done), 32'd1);
      chk_eq("b2b_mflo_dout", bus.dataOut, 32'd0);
      chk_eq("b2b_hi_kept", bus.hi, 32'd1);
      tick();
      chk_eq("b2b_done_clr", 32'(bus.done), 32'd0);

      // A second MULTU arriving at iteration 10 must be dropped
      issue(FUNCT_MULTU, 32'd2, 32'd3);
      repeat (9) tick();
      bus.start = 1'b1;
      bus.funct = FUNCT_MULTU;
      bus.dataA = 32'd7;
      bus.dataB = 32'd9;
      tick();
      bus.start = 1'b0;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done) pulses++;
         tick();
      end
      chk_eq("ign_pulses", 32'(pulses), 32'd1);
      chk_eq("ign_lo", bus.lo, 32'd6);
      chk_eq("ign_hi", bus.hi, 32'd0);

      // Reset in the middle of a multiply aborts it and clears HI/LO
      issue(FUNCT_MULTU, 32'h0000_FFFF, 32'h0000_FFFF);
      repeat (15) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_eq("abort_busy", 32'(bus.busy), 32'd0);
      chk_eq("abort_done", 32'(bus.done), 32'd0);
      chk_eq("abort_hi", bus.hi, 32'd0);
      chk_eq("abort_lo", bus.lo, 32'd0);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done || bus.busy) pulses++;
         tick();
      end
      chk_eq("abort_quiet", 32'(pulses), 32'd0);

      issue(FUNCT_ADD, 32'd1, 32'd2);
      chk_eq("add_done", 32'(bus.done), 32'd0);
      chk_eq("add_busy", 32'(bus.busy), 32'd0);
      tick();
      chk_eq("add_done2", 32'(bus.done), 32'd0);
      issue(FUNCT_MFHI, 32'd0, 32'd0);
      chk_eq("post_mfhi_done", 32'(bus.done), 32'd1);
      chk_eq("post_mfhi_dout", bus.dataOut, 32'd0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
